// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between the IF and ID stages. It buffers {instruction, pc, fault}
// so an ID stall never forces IF to drop an outstanding fetch. There is no bypass path.
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_instruction,
  input  logic [XLEN-1:0]          in_pc,
  input  logic                     in_fault,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_instruction,
  output logic [XLEN-1:0]          out_pc,
  output logic                     out_fault,
  input  logic                     out_stall,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic [XLEN-1:0]  instr_mem [DEPTH];
  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic             fault_mem [DEPTH];

  logic push;
  logic pop;

  // in_ready is a function of registered state only, so ID stall never reaches IF combinationally
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0) && !flush;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && !out_stall;

  assign out_instruction = instr_mem[rd_ptr];
  assign out_pc          = pc_mem[rd_ptr];
  assign out_fault       = fault_mem[rd_ptr];
  assign occupancy       = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; contents are don't-care while out_valid is low
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= in_instruction;
      pc_mem[wr_ptr]    <= in_pc;
      fault_mem[wr_ptr] <= in_fault;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue. A negedge scoreboard tracks the expected contents and checks the
// handshake outputs and every popped head; scenario tasks add their own targeted checks.
module tb_if_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            fault;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [XLEN-1:0]  in_instruction;
  logic [XLEN-1:0]  in_pc;
  logic             in_fault;
  logic             in_ready;
  logic             out_valid;
  logic [XLEN-1:0]  out_instruction;
  logic [XLEN-1:0]  out_pc;
  logic             out_fault;
  logic             out_stall;
  logic [OCC_W-1:0] occupancy;

  int   n_chk  = 0;
  int   n_fail = 0;
  ent_t sb[$];

  if_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_instruction(in_instruction), .in_pc(in_pc), .in_fault(in_fault),
    .in_ready(in_ready), .out_valid(out_valid), .out_instruction(out_instruction),
    .out_pc(out_pc), .out_fault(out_fault), .out_stall(out_stall), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Scoreboard: model state is sb.size(); compares outputs mid-cycle, then applies the edge
  always @(negedge clk) begin
    logic exp_rdy;
    logic exp_vld;
    ent_t e;
    ent_t got;
    if (rst) begin
      exp_rdy = (sb.size() != DEPTH);
      exp_vld = (sb.size() != 0) && !flush;
      n_chk++;
      if (in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL sb_in_ready: got %b expected %b at %0t", in_ready, exp_rdy, $time);
      end
      n_chk++;
      if (out_valid !== exp_vld) begin
        n_fail++;
        $display("FAIL sb_out_valid: got %b expected %b at %0t", out_valid, exp_vld, $time);
      end
      n_chk++;
      if (occupancy !== OCC_W'(sb.size())) begin
        n_fail++;
        $display("FAIL sb_occupancy: got %0d expected %0d at %0t", occupancy, sb.size(), $time);
      end
      if (exp_vld && !out_stall) begin
        e   = sb.pop_front();
        got = '{instr: out_instruction, pc: out_pc, fault: out_fault};
        n_chk++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL sb_head: got instr=%h pc=%h fault=%b expected instr=%h pc=%h fault=%b at %0t",
                   got.instr, got.pc, got.fault, e.instr, e.pc, e.fault, $time);
        end
      end
      if (flush) sb.delete();
      else if (in_valid && exp_rdy) sb.push_back('{instr: in_instruction, pc: in_pc, fault: in_fault});
    end
  end

  // Inputs change 2 time units after a rising edge and hold through the next one
  task automatic drive(input logic v, input logic [XLEN-1:0] instr, input logic [XLEN-1:0] pc,
                       input logic f, input logic stall, input logic fl);
    @(posedge clk);
    #2;
    in_valid       = v;
    in_instruction = instr;
    in_pc          = pc;
    in_fault       = f;
    out_stall      = stall;
    flush          = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instruction = '0;
    in_pc = '0; in_fault = 1'b0; out_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || occupancy !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b occ=%0d expected 1 0 0", in_ready, out_valid, occupancy);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      #4;
      n_chk++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || occupancy !== '0) begin
        n_fail++;
        $display("FAIL empty_stall: got rdy=%b vld=%b occ=%0d expected 1 0 0", in_ready, out_valid, occupancy);
      end
    end
  endtask

  task automatic test_streaming;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h13 + i, 32'(4 * i), 1'b0, 1'b0, 1'b0);
      #4;
      n_chk++;
      if (occupancy > OCC_W'(1)) begin
        n_fail++;
        $display("FAIL stream_occ: got %0d expected <=1", occupancy);
      end
      if (i == 0) begin
        n_chk++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_no_bypass: got out_valid=%b expected 0", out_valid);
        end
      end else if (i == 1) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
          n_fail++;
          $display("FAIL stream_first: got vld=%b pc=%h expected 1 00000000", out_valid, out_pc);
        end
      end
    end
    idle(3);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL stream_drain: got %0d left expected 0", sb.size());
    end
  endtask

  task automatic test_fill_full;
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h1000 + i, 32'h100 + 32'(4 * i), 1'b0, 1'b1, 1'b0);
    #4;
    n_chk++;
    if (in_ready !== 1'b0 || occupancy !== OCC_W'(4)) begin
      n_fail++;
      $display("FAIL full_state: got rdy=%b occ=%0d expected 0 4", in_ready, occupancy);
    end
    drive(1'b1, 32'h1004, 32'h110, 1'b0, 1'b1, 1'b0);
    #4;
    n_chk++;
    if (occupancy !== OCC_W'(4)) begin
      n_fail++;
      $display("FAIL full_hold: got occ=%0d expected 4", occupancy);
    end
    drive(1'b1, 32'h1004, 32'h110, 1'b0, 1'b0, 1'b0);
    #4;
    n_chk++;
    if (in_ready !== 1'b0 || out_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL full_release: got rdy=%b pc=%h expected 0 00000100", in_ready, out_pc);
    end
    drive(1'b1, 32'h1004, 32'h110, 1'b0, 1'b0, 1'b0);
    #4;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_ready_back: got rdy=%b expected 1", in_ready);
    end
    idle(6);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL full_drain: got %0d left expected 0", sb.size());
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 32'h3000, 32'h300, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h3001, 32'h304, 1'b0, 1'b1, 1'b0);
    for (int i = 2; i < 9; i++) begin
      drive(1'b1, 32'h3000 + i, 32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      #4;
      n_chk++;
      if (occupancy !== OCC_W'(2)) begin
        n_fail++;
        $display("FAIL pushpop_occ: got %0d expected 2 (step %0d)", occupancy, i);
      end
    end
    idle(4);
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h4000 + i, 32'h400 + 32'(4 * i), 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h4003, 32'h40C, 1'b0, 1'b0, 1'b1);
    #4;
    n_chk++;
    if (out_valid !== 1'b0 || occupancy !== OCC_W'(3)) begin
      n_fail++;
      $display("FAIL flush_cycle: got vld=%b occ=%0d expected 0 3", out_valid, occupancy);
    end
    drive(1'b1, 32'h2222, 32'h200, 1'b0, 1'b1, 1'b0);
    #4;
    n_chk++;
    if (occupancy !== '0) begin
      n_fail++;
      $display("FAIL flush_after: got occ=%0d expected 0", occupancy);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #4;
    n_chk++;
    if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_instruction !== 32'h2222) begin
      n_fail++;
      $display("FAIL flush_first_pc: got vld=%b pc=%h expected 1 00000200", out_valid, out_pc);
    end
    idle(2);
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h5000 + i, 32'h500 + 32'(4 * i), 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    n_chk++;
    if (occupancy !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got occ=%0d vld=%b rdy=%b expected 0 0 1", occupancy, out_valid, in_ready);
    end
    #1 rst = 1'b1;
    drive(1'b1, 32'hDEAD0001, 32'h600, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #4;
    n_chk++;
    if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_pc !== 32'h600) begin
      n_fail++;
      $display("FAIL fault_entry: got vld=%b fault=%b pc=%h expected 1 1 00000600", out_valid, out_fault, out_pc);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_fill_full();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
